// File: rtl/decode_pipe_if.sv
// IF/ID -> ID/EX bundle for the decode stage.
// master drives the IF/ID side, slave is the stage.
interface decode_pipe_if #(
  parameter int len  = 32,
  parameter int NB   = 5,
  parameter int EXB  = 4,
  parameter int MEMB = 3,
  parameter int WBB  = 2
);
  logic            in_valid;
  logic [len-1:0]  in_pc_jump;
  logic [31:0]     in_instruccion;
  logic [EXB-1:0]  in_execute_bus;
  logic [MEMB-1:0] in_memory_bus;
  logic [WBB-1:0]  in_writeBack_bus;

  logic            out_valid;
  logic [len-1:0]  out_pc_jump;
  logic [len-1:0]  out_reg1;
  logic [len-1:0]  out_reg2;
  logic [len-1:0]  out_sign_extend;
  logic [NB-1:0]   out_rs;
  logic [NB-1:0]   out_rt;
  logic [NB-1:0]   out_rd;
  logic [4:0]      out_shamt;
  logic [EXB-1:0]  execute_bus;
  logic [MEMB-1:0] memory_bus;
  logic [WBB-1:0]  writeBack_bus;

  modport master (
    output in_valid, in_pc_jump, in_instruccion,
    output in_execute_bus, in_memory_bus, in_writeBack_bus,
    input  out_valid, out_pc_jump, out_reg1, out_reg2,
    input  out_sign_extend, out_rs, out_rt, out_rd, out_shamt,
    input  execute_bus, memory_bus, writeBack_bus
  );

  modport slave (
    input  in_valid, in_pc_jump, in_instruccion,
    input  in_execute_bus, in_memory_bus, in_writeBack_bus,
    output out_valid, out_pc_jump, out_reg1, out_reg2,
    output out_sign_extend, out_rs, out_rt, out_rd, out_shamt,
    output execute_bus, memory_bus, writeBack_bus
  );
endinterface

// File: rtl/decode_pipe.sv
// MIPS decode stage: regfile, imm extend, load-use
// hazard, registered ID/EX entry, stall counter.
module decode_pipe #(
  parameter int len  = 32,
  parameter int NREG = 32,
  parameter int NB   = $clog2(NREG),
  parameter int EXB  = 4,
  parameter int MEMB = 3,
  parameter int WBB  = 2,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  decode_pipe_if.slave    bus,
  input  logic            RegWrite,
  input  logic [NB-1:0]   write_register,
  input  logic [len-1:0]  write_data,
  input  logic            ex_MemRead,
  input  logic [NB-1:0]   ex_rt,
  input  logic            flush,
  output logic            out_stall,
  output logic [CNTW-1:0] out_stall_count
);

  localparam int FW = (NB < 5) ? NB : 5;

  function automatic logic [NB-1:0] field(
    input logic [4:0] f
  );
    logic [NB-1:0] r;
    r = '0;
    r[FW-1:0] = f[FW-1:0];
    return r;
  endfunction

  logic [len-1:0] rf [NREG];
  logic [31:0]    ins;
  logic [NB-1:0]  rs, rt, rd;
  logic           zext;
  logic [len-1:0] imm;
  logic [len-1:0] rd1, rd2;
  logic           wr_en;
  logic           bubble;

  assign ins   = bus.in_instruccion;
  assign rs    = field(ins[25:21]);
  assign rt    = field(ins[20:16]);
  assign rd    = field(ins[15:11]);
  assign wr_en = RegWrite && (write_register != '0);

  // andi/ori/xori/lui share the 0011xx opcode group
  assign zext = (ins[31:26] & 6'b111100) == 6'b001100;

  // immediate extension
  always_comb begin
    imm = '0;
    if (zext) imm = len'(ins[15:0]);
    else      imm = len'(signed'(ins[15:0]));
  end

  // register reads with same-cycle write-through
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs != '0)
      rd1 = (wr_en && write_register == rs)
            ? write_data : rf[rs];
    if (rt != '0)
      rd2 = (wr_en && write_register == rt)
            ? write_data : rf[rt];
  end

  assign out_stall = bus.in_valid & ex_MemRead
                   & (ex_rt != '0)
                   & ((ex_rt == rs) | (ex_rt == rt))
                   & ~flush;

  assign bubble = flush | out_stall | ~bus.in_valid;

  // register file storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[write_register] <= write_data;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      bus.out_valid       <= 1'b0;
      bus.out_pc_jump     <= '0;
      bus.out_reg1        <= '0;
      bus.out_reg2        <= '0;
      bus.out_sign_extend <= '0;
      bus.out_rs          <= '0;
      bus.out_rt          <= '0;
      bus.out_rd          <= '0;
      bus.out_shamt       <= '0;
      bus.execute_bus     <= '0;
      bus.memory_bus      <= '0;
      bus.writeBack_bus   <= '0;
    end else begin
      bus.out_valid       <= 1'b1;
      bus.out_pc_jump     <= bus.in_pc_jump;
      bus.out_reg1        <= rd1;
      bus.out_reg2        <= rd2;
      bus.out_sign_extend <= imm;
      bus.out_rs          <= rs;
      bus.out_rt          <= rt;
      bus.out_rd          <= rd;
      bus.out_shamt       <= ins[10:6];
      bus.execute_bus     <= bus.in_execute_bus;
      bus.memory_bus      <= bus.in_memory_bus;
      bus.writeBack_bus   <= bus.in_writeBack_bus;
    end
  end

  // saturating stall-cycle counter
  always_ff @(posedge clk) begin
    if (reset)
      out_stall_count <= '0;
    else if (out_stall && out_stall_count != '1)
      out_stall_count <= out_stall_count + 1'b1;
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe; a second
// instance with a 2-bit counter checks saturation.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        ex_MemRead;
  logic [4:0]  ex_rt;
  logic        flush;
  logic        stall_a, stall_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int n_run  = 0;
  int n_fail = 0;

  decode_pipe_if b1 ();
  decode_pipe_if b2 ();

  assign b2.in_valid         = b1.in_valid;
  assign b2.in_pc_jump       = b1.in_pc_jump;
  assign b2.in_instruccion   = b1.in_instruccion;
  assign b2.in_execute_bus   = b1.in_execute_bus;
  assign b2.in_memory_bus    = b1.in_memory_bus;
  assign b2.in_writeBack_bus = b1.in_writeBack_bus;

  decode_pipe dut (
    .clk(clk), .reset(reset), .bus(b1),
    .RegWrite(RegWrite),
    .write_register(write_register),
    .write_data(write_data),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .flush(flush), .out_stall(stall_a),
    .out_stall_count(cnt_a)
  );

  decode_pipe #(.CNTW(2)) dut2 (
    .clk(clk), .reset(reset), .bus(b2),
    .RegWrite(RegWrite),
    .write_register(write_register),
    .write_data(write_data),
    .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .flush(flush), .out_stall(stall_b),
    .out_stall_count(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic decode(
    input logic [31:0] ins,
    input logic        v
  );
    b1.in_instruccion = ins;
    b1.in_valid       = v;
  endtask

  task automatic bubble_chk(input string tag);
    check({tag, ".valid"}, 64'(b1.out_valid), 0);
    check({tag, ".ex"}, 64'(b1.execute_bus), 0);
    check({tag, ".mem"}, 64'(b1.memory_bus), 0);
    check({tag, ".wb"}, 64'(b1.writeBack_bus), 0);
    check({tag, ".r1"}, 64'(b1.out_reg1), 0);
  endtask

  initial begin
    reset            = 1'b1;
    RegWrite         = 1'b1;
    write_register   = 5'd5;
    write_data       = 32'hCAFE_F00D;
    ex_MemRead       = 1'b0;
    ex_rt            = 5'd0;
    flush            = 1'b0;
    b1.in_pc_jump       = 32'h104;
    b1.in_execute_bus   = 4'hA;
    b1.in_memory_bus    = 3'h5;
    b1.in_writeBack_bus = 2'h3;
    decode(32'h00A0_0820, 1'b1);

    // reset wins over RegWrite
    tick();
    tick();
    bubble_chk("rst");
    check("rst.pc", 64'(b1.out_pc_jump), 0);
    check("rst.rd", 64'(b1.out_rd), 0);
    check("rst.cnt", 64'(cnt_a), 0);
    check("rst.cnt2", 64'(cnt_b), 0);
    check("rst.valid2", 64'(b2.out_valid), 0);

    // r5 must not hold the write issued in reset
    reset    = 1'b0;
    RegWrite = 1'b0;
    tick();
    check("r5.valid", 64'(b1.out_valid), 1);
    check("r5.r1", 64'(b1.out_reg1), 0);
    check("r5.rs", 64'(b1.out_rs), 5);

    // write r3, decode add $1,$3,$0
    RegWrite       = 1'b1;
    write_register = 5'd3;
    write_data     = 32'hDEAD_BEEF;
    decode(32'h0000_0000, 1'b0);
    tick();
    check("inv.valid", 64'(b1.out_valid), 0);
    RegWrite = 1'b0;
    decode(32'h0060_0820, 1'b1);
    tick();
    check("add.valid", 64'(b1.out_valid), 1);
    check("add.r1", 64'(b1.out_reg1), 64'hDEADBEEF);
    check("add.r2", 64'(b1.out_reg2), 0);
    check("add.rd", 64'(b1.out_rd), 1);
    check("add.rs", 64'(b1.out_rs), 3);
    check("add.pc", 64'(b1.out_pc_jump), 64'h104);
    check("add.ex", 64'(b1.execute_bus), 64'hA);
    check("add.mem", 64'(b1.memory_bus), 64'h5);
    check("add.wb", 64'(b1.writeBack_bus), 64'h3);

    // write-through of r4 in the decode cycle
    RegWrite       = 1'b1;
    write_register = 5'd4;
    write_data     = 32'h1234_5678;
    decode(32'h0080_0820, 1'b1);
    tick();
    check("wt.r1", 64'(b1.out_reg1), 64'h12345678);

    // write to r0 is dropped, r4 persists
    write_register = 5'd0;
    write_data     = 32'hFFFF_FFFF;
    decode(32'h0004_0820, 1'b1);
    tick();
    check("r0.r1", 64'(b1.out_reg1), 0);
    check("r0.r2", 64'(b1.out_reg2), 64'h12345678);
    RegWrite = 1'b0;
    decode(32'h0000_0820, 1'b1);
    tick();
    check("r0.rd", 64'(b1.out_reg1), 0);

    // immediates and shamt
    decode(32'h2000_FFFF, 1'b1);
    tick();
    check("addi.neg", 64'(b1.out_sign_extend),
          64'hFFFFFFFF);
    decode(32'h3400_FFFF, 1'b1);
    tick();
    check("ori", 64'(b1.out_sign_extend),
          64'h0000FFFF);
    decode(32'h2000_7FFF, 1'b1);
    tick();
    check("addi.pos", 64'(b1.out_sign_extend),
          64'h00007FFF);
    decode(32'h3C01_8000, 1'b1);
    tick();
    check("lui", 64'(b1.out_sign_extend),
          64'h00008000);
    decode(32'h0000_0740, 1'b1);
    tick();
    check("shamt", 64'(b1.out_shamt), 29);

    // load-use stall on rs
    ex_MemRead = 1'b1;
    ex_rt      = 5'd2;
    decode(32'h0040_0820, 1'b1);
    #1;
    check("ld.stall", 64'(stall_a), 1);
    tick();
    bubble_chk("ld");
    check("ld.cnt", 64'(cnt_a), 1);
    ex_MemRead = 1'b0;
    #1;
    check("ld.nostall", 64'(stall_a), 0);
    tick();
    check("ld.valid", 64'(b1.out_valid), 1);
    check("ld.rs", 64'(b1.out_rs), 2);

    // stall on rt, none for ex_rt=0 or invalid
    ex_MemRead = 1'b1;
    ex_rt      = 5'd4;
    decode(32'h0004_0820, 1'b1);
    #1;
    check("rt.stall", 64'(stall_a), 1);
    decode(32'h0004_0820, 1'b0);
    #1;
    check("inv.stall", 64'(stall_a), 0);
    ex_rt = 5'd0;
    decode(32'h0000_0820, 1'b1);
    #1;
    check("r0.stall", 64'(stall_a), 0);
    tick();
    check("r0.cnt", 64'(cnt_a), 1);

    // flush beats the stall
    ex_rt = 5'd2;
    flush = 1'b1;
    decode(32'h0040_0820, 1'b1);
    #1;
    check("fl.stall", 64'(stall_a), 0);
    tick();
    bubble_chk("fl");
    check("fl.cnt", 64'(cnt_a), 1);

    // five stall cycles: narrow counter saturates
    flush = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("sat.cnt", 64'(cnt_a), 6);
    check("sat.cnt2", 64'(cnt_b), 3);

    // reset clears counter and register file
    ex_MemRead = 1'b0;
    reset      = 1'b1;
    tick();
    check("rst2.cnt", 64'(cnt_a), 0);
    check("rst2.cnt2", 64'(cnt_b), 0);
    reset = 1'b0;
    decode(32'h0060_0820, 1'b1);
    tick();
    check("rst2.r3", 64'(b1.out_reg1), 0);
    check("rst2.valid", 64'(b1.out_valid), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised next-generation MIPS instruction-decode stage: register file, immediate extension, load-use hazard detection, ID/EX pipeline register with stall/flush, saturating stall counter.
- Sits between the IF/ID register and the execute stage.
- Control buses come precomputed from the control unit on `in_*_bus`.
- Unlike the previous combinational decode, every output is registered.

Parameters:
- len, 32, datapath width (bits)
- NREG, 32, number of architectural registers (power of 2, ≥2)
- NB, $clog2(NREG), register index width
- EXB, 4, execute control bus width
- MEMB, 3, memory control bus width
- WBB, 2, write-back control bus width
- CNTW, 16, stall counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  IF/ID holds a real instruction
- in_pc_jump  in  len  PC+4 of the instruction
- in_instruccion  in  32  instruction word
- in_execute_bus  in  EXB  control for EX
- in_memory_bus  in  MEMB  control for MEM
- in_writeBack_bus  in  WBB  control for WB
- RegWrite  in  1  WB write enable
- write_register  in  NB  WB destination index
- write_data  in  len  WB data
- ex_MemRead  in  1  instruction currently in EX is a load
- ex_rt  in  NB  destination of that load
- flush  in  1  branch/jump taken downstream; kill the ID instruction
- out_stall  out  1  combinational; hold PC and IF/ID this cycle
- out_valid  out  1  ID/EX entry is real
- out_pc_jump  out  len  registered PC+4
- out_reg1, out_reg2  out  len  registered rs/rt operands
- out_sign_extend  out  len  registered extended immediate
- out_rs, out_rt, out_rd, out_shamt  out  NB/NB/NB/5  registered fields (for forwarding unit)
- execute_bus  out  EXB  registered control
- memory_bus  out  MEMB  registered control
- writeBack_bus  out  WBB  registered control
- out_stall_count  out  CNTW  saturating count of stall cycles

Behaviour:
- Reset (clk edge with reset=1):
  - All registered outputs go to 0.
  - All NREG registers are cleared to 0.
  - out_stall_count goes to 0.
  - reset overrides flush, stall and RegWrite.
- Register file:
  - Write on the edge when RegWrite=1 and write_register≠0.
  - Register 0 always reads 0.
  - Read is combinational with write-through: if RegWrite=1, write_register≠0 and write_register equals the read index, the read returns write_data in the same cycle.
- Fields: rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6].
  - When NB<5, the low NB bits of each field are used.
  - When NB>5, each field is zero-extended.
- Immediate extension:
  - Opcode [31:28]=4'b0011 (andi/ori/xori/lui): zero-extend [15:0].
  - All other opcodes: sign-extend [15:0] to len.
- Hazard: out_stall = in_valid & ex_MemRead & (ex_rt≠0) & ((ex_rt==rs) | (ex_rt==rt)) & ~flush.
- ID/EX update each edge, in priority order (first match wins):
  1. reset: cleared as above.
  2. flush=1: bubble, regardless of stall.
  3. out_stall=1: bubble.
  4. in_valid=0: bubble.
  5. Otherwise: load every field; out_valid=1.
- Bubble definition: out_valid=0, execute_bus/memory_bus/writeBack_bus=0, all data and field outputs=0.
- Latency: exactly 1 cycle from IF/ID inputs to ID/EX outputs.
- Stall duration: a load-use stall lasts 1 cycle, because the load leaves EX the next cycle. The IF/ID input is held externally and is re-decoded with no hazard.
- Stall counter:
  - Increments by 1 on each edge where out_stall=1.
  - Saturates at 2^CNTW−1; never wraps.
  - Cleared only by reset.
- Simultaneous WB write and ID read of the same register: the new value is captured into out_reg1/out_reg2.

Test Plan:
- Reset, then read: reset=1 for 2 cycles with RegWrite=1 → all outputs 0, count 0. Read r5 afterwards → 0.
- Write and read back: write r3=0xDEADBEEF; next cycle decode `add $1,$3,$0` (0x00600820) → after 1 cycle out_reg1=0xDEADBEEF, out_reg2=0, out_rd=1, out_valid=1, buses equal inputs.
- Write-through and r0: in the same cycle write r4=0x12345678 and decode an instruction with rs=4 → out_reg1=0x12345678 next edge. A write to r0 → r0 still reads 0.
- Immediate modes:
  - imm 0xFFFF with opcode addi (0x08) → out_sign_extend=0xFFFFFFFF.
  - Opcode ori (0x0D) → 0x0000FFFF.
- Load-use stall: ex_MemRead=1, ex_rt=2, instruction rs=2, in_valid=1 → out_stall=1 → next edge is a bubble (valid 0, buses 0) and count=1. The next cycle, with ex_MemRead=0, the same instruction loads with out_valid=1.
- Flush priority and saturation:
  - Flush with a stall condition present → out_stall=0, bubble, count unchanged.
  - With CNTW=2, 5 stall cycles → count saturates at 3.
